line_refill_adapter: RTL and testbench

Bridges the cache-line memory port of the instruction/data caches to the 32-bit system bus. It accepts one 128-bit line request (read refill or write-back), runs it as four sequential 32-bit bus beats, assembles or serialises the line, and returns a single-cycle `mem_ready` completion. It sits directly below the cache, feeding `mem_rdata`/`mem_ready` back to the cache's REFILL state.

---
 rtl/line_refill_adapter_pkg.sv | 14 +
 rtl/line_refill_adapter.sv | 103 ++++++++++
 tb/tb_line_refill_adapter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/line_refill_adapter_pkg.sv
// rtl/line_refill_adapter_pkg.sv - shared widths and state encoding for the line refill adapter
package line_refill_adapter_pkg;

    localparam int LINE_W = 128;
    localparam int BUS_W  = 32;
    localparam int BEATS  = LINE_W / BUS_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/line_refill_adapter.sv
// rtl/line_refill_adapter.sv - runs one 128-bit cache line request as four ascending 32-bit bus beats
module line_refill_adapter
    import line_refill_adapter_pkg::*;
#(
    parameter int LINE_W_P = LINE_W,
    parameter int BUS_W_P  = BUS_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [31:0]         mem_addr,
    input  logic [LINE_W_P-1:0] mem_wdata,
    output logic [LINE_W_P-1:0] mem_rdata,
    output logic                mem_ready,
    output logic                bus_req,
    output logic                bus_we,
    output logic [31:0]         bus_addr,
    output logic [BUS_W_P-1:0]  bus_wdata,
    input  logic [BUS_W_P-1:0]  bus_rdata,
    input  logic                bus_ready
);

    state_t              state_q;
    logic [1:0]          beat_q;
    logic [31:0]         base_q;
    logic                we_q;
    logic [LINE_W_P-1:0] wline_q;
    logic [LINE_W_P-1:0] rdata_q;
    logic                mem_ready_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [31:0]         bus_addr_q;
    logic [BUS_W_P-1:0]  bus_wdata_q;

    logic [1:0]          beat_d;
    logic [31:0]         line_base_d;

    assign beat_d      = beat_q + 2'd1;
    assign line_base_d = mem_addr & 32'hFFFF_FFF0;

    // Bus outputs are loaded one beat ahead so they are already valid in the cycle a beat is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= 2'd0;
            base_q      <= 32'd0;
            we_q        <= 1'b0;
            wline_q     <= '0;
            rdata_q     <= '0;
            mem_ready_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        base_q      <= line_base_d;
                        we_q        <= mem_we;
                        wline_q     <= mem_wdata;
                        beat_q      <= 2'd0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we;
                        bus_addr_q  <= line_base_d;
                        bus_wdata_q <= mem_wdata[BUS_W_P-1:0];
                        state_q     <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (bus_ready) begin
                        if (!we_q) begin
                            rdata_q[{beat_q, 5'b0} +: BUS_W_P] <= bus_rdata;
                        end
                        if (beat_q == 2'd3) begin
                            bus_req_q   <= 1'b0;
                            mem_ready_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            beat_q      <= beat_d;
                            bus_addr_q  <= base_q + {28'd0, beat_d, 2'b00};
                            bus_wdata_q <= wline_q[{beat_d, 5'b0} +: BUS_W_P];
                        end
                    end
                end
                ST_DONE: begin
                    mem_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = mem_ready_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_line_refill_adapter.sv
// tb/tb_line_refill_adapter.sv - scoreboard bench for line_refill_adapter
module tb_line_refill_adapter;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_req = 1'b0;
    logic         mem_we = 1'b0;
    logic [31:0]  mem_addr = 32'd0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata = 32'd0;
    logic         bus_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    beat_t        beat_q[$];
    logic [127:0] rd_q[$];
    logic [127:0] model_rd = '0;

    line_refill_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    // Drives one line request; expected beats and line are queued up front and popped as the DUT delivers them.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [127:0] wline,
                           input logic [127:0] rline, input int wait_beat, input int wait_n);
        int cyc, k, waited;
        logic done;
        beat_t exp;
        logic [127:0] exp_line;
        for (int i = 0; i < 4; i++)
            beat_q.push_back('{addr: (addr & 32'hFFFF_FFF0) + 32'(4 * i), we: we, wdata: wline[32*i +: 32]});
        if (!we) model_rd = rline;
        rd_q.push_back(model_rd);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wline;
        cyc = 0; k = 0; waited = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                mem_addr = ~addr; mem_we = ~we; mem_wdata = ~wline;
            end
            if (mem_ready) begin
                exp_line = rd_q.pop_front();
                checks++;
                if (mem_rdata !== exp_line) begin
                    errors++; $display("FAIL rdata: got %h expected %h", mem_rdata, exp_line);
                end
                checks++;
                if (cyc - 1 != 4 + wait_n) begin
                    errors++; $display("FAIL ready_edge: got E%0d expected E%0d", cyc - 1, 4 + wait_n);
                end
                checks++;
                if (beat_q.size() != 0 || bus_req !== 1'b0) begin
                    errors++; $display("FAIL beats_left: got %0d left bus_req=%b expected 0 left bus_req=0", beat_q.size(), bus_req);
                end
                mem_req = 1'b0; bus_ready = 1'b0; done = 1'b1;
            end else if (bus_req) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++; $display("FAIL extra_beat: got bus_req=1 expected no more beats");
                    bus_ready = 1'b1;
                end else begin
                    exp = beat_q[0];
                    if (bus_addr !== exp.addr || bus_we !== exp.we || bus_wdata !== exp.wdata) begin
                        errors++;
                        $display("FAIL beat%0d: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                                 k, bus_addr, bus_we, bus_wdata, exp.addr, exp.we, exp.wdata);
                    end
                    if (k == wait_beat && waited < wait_n) begin
                        bus_ready = 1'b0; waited++;
                    end else begin
                        bus_ready = 1'b1;
                        bus_rdata = we ? $urandom : rline[32*k +: 32];
                        void'(beat_q.pop_front());
                        k++;
                    end
                end
            end else begin
                bus_ready = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: got no mem_ready expected within 40 cycles");
            beat_q.delete(); rd_q.delete(); mem_req = 1'b0; bus_ready = 1'b0;
        end else begin
            @(negedge clk);
            checks++;
            if (mem_ready !== 1'b0) begin
                errors++; $display("FAIL ready_pulse: got %b expected 0", mem_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_ready, bus_req, bus_we, bus_addr, bus_wdata, mem_rdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got ready=%b req=%b we=%b addr=%h wdata=%h rdata=%h expected all 0",
                               mem_ready, bus_req, bus_we, bus_addr, bus_wdata, mem_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_ready();
        bus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus_req !== 1'b0 || mem_ready !== 1'b0) begin
                errors++; $display("FAIL idle_ready: got req=%b ready=%b expected 0 0", bus_req, mem_ready);
            end
        end
        bus_ready = 1'b0;
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'h0000_1234, '0,
                128'h44444444_33333333_22222222_11111111, -1, 0);
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'h0000_5678, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0, -1, 0);
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, 32'h0000_0A08, '0,
                128'h0BADF00D_CAFEBABE_12345678_DEADBEEF, 1, 2);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'hFFFF_FFFC, '0,
                128'h89ABCDEF_01234567_76543210_FEDCBA98, -1, 0);
        run_txn(1'b0, 32'h0000_2000, '0,
                128'h2000000C_20000008_20000004_20000000, -1, 0);
    endtask

    task automatic test_reset_mid();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_3000;
        @(negedge clk); bus_ready = 1'b1; bus_rdata = 32'h5555_0000;
        @(negedge clk); bus_ready = 1'b1; bus_rdata = 32'h5555_0001;
        @(negedge clk); bus_ready = 1'b0;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_3008 || mem_rdata[63:0] !== 64'h55550001_55550000) begin
            errors++; $display("FAIL mid_partial: got req=%b addr=%h rdata_lo=%h expected 1 00003008 5555000155550000",
                               bus_req, bus_addr, mem_rdata[63:0]);
        end
        rst_n = 1'b0; mem_req = 1'b0;
        #1;
        checks++;
        if ({mem_ready, bus_req, bus_we, bus_addr, bus_wdata, mem_rdata} !== '0) begin
            errors++; $display("FAIL mid_reset: got ready=%b req=%b addr=%h rdata=%h expected all 0",
                               mem_ready, bus_req, bus_addr, mem_rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        model_rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_ready !== 1'b0 || bus_req !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle: got ready=%b req=%b expected 0 0", mem_ready, bus_req);
            end
        end
        run_txn(1'b0, 32'h0000_3000, '0,
                128'h66666666_77777777_88888888_99999999, -1, 0);
    endtask

    initial begin
        test_reset();
        test_idle_ready();
        test_read();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
